// File: rtl/cv32e40x_amo_sequencer.sv
// Executes RV32A word operations (LR/SC/AMO*) as split read/write OBI transactions.
// Optional LR->SC reservation timeout is enabled by defining CV32E40X_AMO_RESV_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a request; SC reservation check happens here
// S_RD_REQ  | read request on the bus, waiting for grant
// S_RD_WAIT | read granted, waiting for response
// S_WR_REQ  | write request on the bus, waiting for grant
// S_WR_WAIT | write granted, waiting for response
// S_RESP    | result held until consumed
module cv32e40x_amo_sequencer #(
    parameter int unsigned RESV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        amo_valid_i,
    output logic        amo_ready_o,
    input  logic [5:0]  amo_atop_i,
    input  logic [31:0] amo_addr_i,
    input  logic [31:0] amo_wdata_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RESP
    } state_e;

    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_SWAP = 5'b00001;
    localparam logic [4:0] FN_LR   = 5'b00010;
    localparam logic [4:0] FN_SC   = 5'b00011;
    localparam logic [4:0] FN_XOR  = 5'b00100;
    localparam logic [4:0] FN_OR   = 5'b01000;
    localparam logic [4:0] FN_AND  = 5'b01100;
    localparam logic [4:0] FN_MIN  = 5'b10000;
    localparam logic [4:0] FN_MAX  = 5'b10100;
    localparam logic [4:0] FN_MINU = 5'b11000;
    localparam logic [4:0] FN_MAXU = 5'b11100;

    state_e      state_q, state_d;
    logic [4:0]  funct_q, funct_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        resv_valid_q, resv_valid_d;
    logic [31:2] resv_addr_q, resv_addr_d;
    logic        resv_set;
    logic        resv_expired;
    logic        resv_live;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^amo_addr_i[1:0];

    function automatic logic op_supported(input logic [5:0] atop);
        logic known;
        case (atop[4:0])
            FN_ADD, FN_SWAP, FN_LR, FN_SC, FN_XOR, FN_OR, FN_AND,
            FN_MIN, FN_MAX, FN_MINU, FN_MAXU: known = 1'b1;
            default:                          known = 1'b0;
        endcase
        return atop[5] & known;
    endfunction

    function automatic logic [31:0] amo_alu(input logic [4:0]  funct,
                                            input logic [31:0] old_val,
                                            input logic [31:0] opnd);
        logic [31:0] res;
        case (funct)
            FN_ADD:  res = old_val + opnd;
            FN_XOR:  res = old_val ^ opnd;
            FN_OR:   res = old_val | opnd;
            FN_AND:  res = old_val & opnd;
            FN_MIN:  res = ($signed(old_val) < $signed(opnd)) ? old_val : opnd;
            FN_MAX:  res = ($signed(old_val) > $signed(opnd)) ? old_val : opnd;
            FN_MINU: res = (old_val < opnd) ? old_val : opnd;
            FN_MAXU: res = (old_val > opnd) ? old_val : opnd;
            default: res = opnd;
        endcase
        return res;
    endfunction

`ifdef CV32E40X_AMO_RESV_TIMEOUT_EN
    // Down-counter; terminal count 0 expires the reservation in that same cycle.
    localparam int unsigned CntW = $clog2(RESV_TIMEOUT + 1);

    logic [CntW-1:0] resv_cnt_q, resv_cnt_d;

    assign resv_expired = resv_valid_q && (resv_cnt_q == '0);

    always_comb begin
        resv_cnt_d = resv_cnt_q;
        if (resv_set) begin
            resv_cnt_d = CntW'(RESV_TIMEOUT);
        end else if (resv_valid_q && !resv_expired) begin
            resv_cnt_d = resv_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_cnt_q <= '0;
        end else begin
            resv_cnt_q <= resv_cnt_d;
        end
    end
`else
    assign resv_expired = 1'b0;
`endif

    assign resv_live = resv_valid_q & ~resv_expired;

    always_comb begin
        state_d      = state_q;
        funct_d      = funct_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resv_valid_d = resv_live;
        resv_addr_d  = resv_addr_q;
        resv_set     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (amo_valid_i) begin
                    funct_d = amo_atop_i[4:0];
                    addr_d  = amo_addr_i[31:2];
                    wdata_d = amo_wdata_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!op_supported(amo_atop_i)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (amo_atop_i[4:0] == FN_SC) begin
                        resv_valid_d = 1'b0;
                        if (resv_live && (resv_addr_q == amo_addr_i[31:2])) begin
                            state_d = S_WR_REQ;
                        end else begin
                            rdata_d = 32'd1;
                            state_d = S_RESP;
                        end
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (bus_gnt_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i;
                    if (bus_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (funct_q == FN_LR) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
                        resv_set     = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        wdata_d = amo_alu(funct_q, bus_rdata_i, wdata_q);
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (bus_gnt_i) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (bus_rvalid_i) begin
                    err_d = bus_err_i;
                    if (funct_q == FN_SC) begin
                        rdata_d = {31'd0, bus_err_i};
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            funct_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            funct_q      <= funct_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

    assign amo_ready_o  = (state_q == S_IDLE);
    assign bus_req_o    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign bus_we_o     = (state_q == S_WR_REQ);
    assign bus_addr_o   = {addr_q[31:2], 2'b00};
    assign bus_wdata_o  = wdata_q;
    assign bus_be_o     = 4'b1111;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_cv32e40x_amo_sequencer.sv
// Self-checking bench for cv32e40x_amo_sequencer: transaction-level memory/reservation
// model, randomized OBI slave timing and error injection, plus directed literal cases.
module tb_cv32e40x_amo_sequencer;

    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_SWAP = 5'b00001;
    localparam logic [4:0] FN_LR   = 5'b00010;
    localparam logic [4:0] FN_SC   = 5'b00011;
    localparam logic [4:0] FN_XOR  = 5'b00100;
    localparam logic [4:0] FN_OR   = 5'b01000;
    localparam logic [4:0] FN_AND  = 5'b01100;
    localparam logic [4:0] FN_MIN  = 5'b10000;
    localparam logic [4:0] FN_MAX  = 5'b10100;
    localparam logic [4:0] FN_MINU = 5'b11000;
    localparam logic [4:0] FN_MAXU = 5'b11100;
    localparam int RESV_TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        amo_valid_i, amo_ready_o;
    logic [5:0]  amo_atop_i;
    logic [31:0] amo_addr_i, amo_wdata_i;
    logic        bus_req_o, bus_gnt_i, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;

    always #5 clk = ~clk;

    cv32e40x_amo_sequencer #(.RESV_TIMEOUT(RESV_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .amo_valid_i  (amo_valid_i),
        .amo_ready_o  (amo_ready_o),
        .amo_atop_i   (amo_atop_i),
        .amo_addr_i   (amo_addr_i),
        .amo_wdata_i  (amo_wdata_i),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [4];
    logic [31:0] bus_mem [4];
    bit          ref_resv;
    logic [29:0] ref_resv_addr;
    int          ref_resv_t;
    bus_t        exp_bus [$];
    bit          pl_rd_err, pl_wr_err;
    int          pl_gdly, pl_rvdly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          txn_active = 1'b0;
    int          wr_count = 0;
    int          grant_count = 0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] got_rdata;
    logic        got_err;
    bus_t        sl_e;
    logic [31:0] sl_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] old,
                                            input logic [31:0] opnd);
        case (f)
            FN_ADD:  return old + opnd;
            FN_XOR:  return old ^ opnd;
            FN_OR:   return old | opnd;
            FN_AND:  return old & opnd;
            FN_MIN:  return ($signed(old) < $signed(opnd)) ? old : opnd;
            FN_MAX:  return ($signed(old) < $signed(opnd)) ? opnd : old;
            FN_MINU: return (old < opnd) ? old : opnd;
            FN_MAXU: return (old < opnd) ? opnd : old;
            default: return opnd;
        endcase
    endfunction

    function automatic bit ref_supported(input bit a5, input logic [4:0] f);
        return a5 && (f inside {FN_ADD, FN_SWAP, FN_LR, FN_SC, FN_XOR, FN_OR, FN_AND,
                                FN_MIN, FN_MAX, FN_MINU, FN_MAXU});
    endfunction

    task automatic set_mem(input int idx, input logic [31:0] v);
        ref_mem[idx] = v;
        bus_mem[idx] = v;
    endtask

    task automatic run_txn(input bit a5, input logic [4:0] f, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit rd_err, input bit wr_err,
                           input int gdly, input int rvdly, input int rrdly);
        int          a, t, n, exp_lat, exp_nbus, g0, idx;
        bit          lr_sets, ok;
        logic [31:0] old, nv, waddr;
        @(negedge clk);
        pl_rd_err   = rd_err;
        pl_wr_err   = wr_err;
        pl_gdly     = gdly;
        pl_rvdly    = rvdly;
        amo_valid_i = 1'b1;
        amo_atop_i  = {a5, f};
        amo_addr_i  = addr;
        amo_wdata_i = wdata;
        a       = cyc;
        g0      = grant_count;
        lr_sets = 1'b0;
        idx     = int'(addr[3:2]);
        old     = ref_mem[idx];
        waddr   = {addr[31:2], 2'b00};
        if (!ref_supported(a5, f)) begin
            exp_rdata = '0; exp_err = 1'b1; exp_lat = 1; exp_nbus = 0;
        end else if (f == FN_LR) begin
            exp_bus.push_back('{1'b0, waddr, 32'h0});
            exp_rdata = old; exp_err = rd_err; exp_lat = 3; exp_nbus = 1;
            if (!rd_err) begin
                ref_resv      = 1'b1;
                ref_resv_addr = addr[31:2];
                lr_sets       = 1'b1;
            end
        end else if (f == FN_SC) begin
            ok = ref_resv && (ref_resv_addr == addr[31:2]);
`ifdef CV32E40X_AMO_RESV_TIMEOUT_EN
            if (a - ref_resv_t >= RESV_TO) ok = 1'b0;
`endif
            ref_resv = 1'b0;
            if (ok) begin
                exp_bus.push_back('{1'b1, waddr, wdata});
                exp_rdata = wr_err ? 32'd1 : 32'd0; exp_err = wr_err; exp_lat = 3; exp_nbus = 1;
                if (!wr_err) ref_mem[idx] = wdata;
            end else begin
                exp_rdata = 32'd1; exp_err = 1'b0; exp_lat = 1; exp_nbus = 0;
            end
        end else begin
            exp_bus.push_back('{1'b0, waddr, 32'h0});
            exp_rdata = old;
            if (rd_err) begin
                exp_err = 1'b1; exp_lat = 3; exp_nbus = 1;
            end else begin
                nv = ref_alu(f, old, wdata);
                exp_bus.push_back('{1'b1, waddr, nv});
                exp_err = wr_err; exp_lat = 5; exp_nbus = 2;
                if (!wr_err) ref_mem[idx] = nv;
            end
        end
        txn_active = 1'b1;
        @(negedge clk);
        amo_valid_i = 1'b0;
        chk("ready_while_busy", {31'd0, amo_ready_o}, 32'd0);
        n = 0;
        while (!resp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid_o) begin
            chk("resp_timeout", {31'd0, resp_valid_o}, 32'd1);
            txn_active = 1'b0;
            exp_bus.delete();
            return;
        end
        t = cyc;
        if (lr_sets) ref_resv_t = t;
        if (gdly == 0 && rvdly == 0) chk("latency", 32'(t - a), 32'(exp_lat));
        repeat (rrdly) @(negedge clk);
        resp_ready_i = 1'b1;
        got_rdata    = resp_rdata_o;
        got_err      = resp_err_o;
        @(negedge clk);
        resp_ready_i = 1'b0;
        txn_active   = 1'b0;
        chk("bus_txn_count", 32'(grant_count - g0), 32'(exp_nbus));
        chk("resp_released", {31'd0, resp_valid_o}, 32'd0);
    endtask

    // OBI slave: random grant/response delays, planned error injection, own memory image
    initial begin
        int idx;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
        forever begin
            @(negedge clk);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
            if (rst_n && bus_req_o) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_req_unexpected", {31'd0, bus_req_o}, 32'd0);
                end else begin
                    sl_e = exp_bus.pop_front();
                    for (int i = 0; i <= pl_gdly; i++) begin
                        if (i > 0) @(negedge clk);
                        chk("bus_req_held", {31'd0, bus_req_o}, 32'd1);
                        chk("bus_we", {31'd0, bus_we_o}, {31'd0, sl_e.we});
                        chk("bus_addr", bus_addr_o, sl_e.addr);
                        if (sl_e.we) chk("bus_wdata", bus_wdata_o, sl_e.data);
                    end
                    bus_gnt_i = 1'b1;
                    grant_count++;
                    sl_wdata = bus_wdata_o;
                    if (sl_e.we) begin
                        wr_count++;
                        last_wr_data = sl_wdata;
                    end
                    @(negedge clk);
                    bus_gnt_i = 1'b0;
                    chk("single_outstanding", {31'd0, bus_req_o}, 32'd0);
                    repeat (pl_rvdly) begin
                        @(negedge clk);
                        chk("single_outstanding", {31'd0, bus_req_o}, 32'd0);
                    end
                    idx = int'(sl_e.addr[3:2]);
                    bus_rvalid_i = 1'b1;
                    if (sl_e.we) begin
                        bus_err_i   = pl_wr_err;
                        bus_rdata_i = $urandom;
                        if (!pl_wr_err) bus_mem[idx] = sl_wdata;
                    end else begin
                        bus_err_i   = pl_rd_err;
                        bus_rdata_i = bus_mem[idx];
                    end
                end
            end
        end
    end

    // Per-cycle comparison of the visible outputs against the model's expectations
    always @(negedge clk) begin
        if (rst_n) begin
            chk("bus_be", {28'd0, bus_be_o}, 32'hF);
            if (txn_active && resp_valid_o) begin
                chk("resp_rdata", resp_rdata_o, exp_rdata);
                chk("resp_err", {31'd0, resp_err_o}, {31'd0, exp_err});
            end
            if (resp_valid_o || bus_req_o) chk("ready_idle_only", {31'd0, amo_ready_o}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [4:0] amo_ops [9] = '{FN_ADD, FN_SWAP, FN_XOR, FN_OR, FN_AND,
                                FN_MIN, FN_MAX, FN_MINU, FN_MAXU};
    logic [31:0] edge_vals [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        int          w0, g0, r;
        logic [4:0]  f;
        bit          a5;
        logic [31:0] addr, wdata;
        rst_n = 1'b1;
        amo_valid_i = 1'b0; amo_atop_i = '0; amo_addr_i = '0; amo_wdata_i = '0;
        resp_ready_i = 1'b0;
        ref_resv = 1'b0; ref_resv_addr = '0; ref_resv_t = 0;
        for (int i = 0; i < 4; i++) set_mem(i, 32'h1000 + 32'(i));
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_amo_ready", {31'd0, amo_ready_o}, 32'd1);
        chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be_o}, 32'hF);
        chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
        rst_n = 1'b1;

        // LR then matching SC
        set_mem(0, 32'hDEAD_BEEF);
        run_txn(1, FN_LR, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        chk("lr_rdata", got_rdata, 32'hDEAD_BEEF);
        w0 = wr_count;
        run_txn(1, FN_SC, 32'h100, 32'd5, 0, 0, 0, 0, 0);
        chk("sc_ok_rdata", got_rdata, 32'd0);
        chk("sc_mem", bus_mem[0], 32'd5);
        chk("sc_one_write", 32'(wr_count - w0), 32'd1);

        // SC to a different address fails without bus traffic and kills the reservation
        run_txn(1, FN_LR, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        g0 = grant_count;
        run_txn(1, FN_SC, 32'h104, 32'd9, 0, 0, 0, 0, 0);
        chk("sc_mismatch_rdata", got_rdata, 32'd1);
        chk("sc_mismatch_no_bus", 32'(grant_count - g0), 32'd0);
        run_txn(1, FN_SC, 32'h100, 32'd9, 0, 0, 0, 0, 0);
        chk("sc_after_clear_rdata", got_rdata, 32'd1);

        // Signed/unsigned max and wrapping add
        set_mem(1, 32'hFFFF_FFFF);
        run_txn(1, FN_MAX, 32'h104, 32'd1, 0, 0, 0, 0, 0);
        chk("amomax_write", last_wr_data, 32'd1);
        chk("amomax_rdata", got_rdata, 32'hFFFF_FFFF);
        set_mem(1, 32'hFFFF_FFFF);
        run_txn(1, FN_MAXU, 32'h104, 32'd1, 0, 0, 0, 0, 0);
        chk("amomaxu_write", last_wr_data, 32'hFFFF_FFFF);
        set_mem(1, 32'hFFFF_FFFF);
        run_txn(1, FN_ADD, 32'h104, 32'd2, 0, 0, 0, 0, 0);
        chk("amoadd_write", last_wr_data, 32'd1);
        chk("amoadd_rdata", got_rdata, 32'hFFFF_FFFF);

        // Read error on SWAP: no write
        w0 = wr_count;
        run_txn(1, FN_SWAP, 32'h108, 32'h1234, 1, 0, 0, 0, 0);
        chk("swap_rderr_err", {31'd0, got_err}, 32'd1);
        chk("swap_rderr_no_write", 32'(wr_count - w0), 32'd0);

        // Slow grant and stalled consumer
        set_mem(3, 32'd10);
        run_txn(1, FN_ADD, 32'h10E, 32'd7, 0, 0, 3, 1, 2);
        chk("slow_add_mem", bus_mem[3], 32'd17);
        chk("slow_add_rdata", got_rdata, 32'd10);

        // Unsupported encodings
        run_txn(0, FN_ADD, 32'h100, 32'd1, 0, 0, 0, 0, 0);
        chk("unsup_atop5_err", {31'd0, got_err}, 32'd1);
        run_txn(1, 5'b00101, 32'h100, 32'd1, 0, 0, 0, 0, 1);
        chk("unsup_funct_err", {31'd0, got_err}, 32'd1);

        // Reset drops the reservation
        run_txn(1, FN_LR, 32'h108, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        ref_resv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, FN_SC, 32'h108, 32'd3, 0, 0, 0, 0, 0);
        chk("sc_after_reset_rdata", got_rdata, 32'd1);

`ifdef CV32E40X_AMO_RESV_TIMEOUT_EN
        run_txn(1, FN_LR, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        run_txn(1, FN_SC, 32'h100, 32'd44, 0, 0, 0, 0, 0);
        chk("to_sc_in_window", got_rdata, 32'd0);
        run_txn(1, FN_LR, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        run_txn(1, FN_SC, 32'h100, 32'd45, 0, 0, 0, 0, 0);
        chk("to_sc_expired", got_rdata, 32'd1);
`endif

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      f = FN_LR;
            else if (r < 35) f = FN_SC;
            else             f = amo_ops[$urandom_range(0, 8)];
            a5 = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 29) == 0) f = 5'b00101;
            addr  = 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
            wdata = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 9) == 0)
                set_mem(int'(addr[3:2]), edge_vals[$urandom_range(0, 4)]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(a5, f, addr, wdata,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                    ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(0, 2));
        end

        for (int i = 0; i < 4; i++) chk("final_mem", bus_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
